// File: rtl/cnb_pkg.sv
// Shared types and helpers for the threshold monitor: FSM state encoding,
// comparator flag sanity check and the default debounce depth.
package cnb_pkg;

    localparam int DEB_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_LOW  = 2'b00,
        ST_RISE = 2'b01,
        ST_HIGH = 2'b10,
        ST_FALL = 2'b11
    } state_t;

    // {AgrtB, AeqB, AlwrB} from a healthy comparator is always exactly one-hot.
    function automatic logic isOneHot(input logic [2:0] flags);
        return (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    endfunction

endpackage

// File: rtl/cnb_debounce_cnt.sv
// Debounce counter for the threshold monitor: counts qualifying samples,
// clear has priority, hit flags the last sample before the level commits.
module cnb_debounce_cnt
    import cnb_pkg::*;
#(
    parameter int DEB = DEB_DEFAULT,
    parameter int CW  = $clog2(DEB + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          hit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The FSM clears or commits whenever hit is set, so cnt stays below DEB.
    assign hit = (cnt == CW'(DEB - 1));

endmodule

// File: rtl/cnb_threshold_monitor.sv
// Debounced "above threshold" level with hysteresis, fed by comparator flags.
// Optional rise-event counter enabled by defining CNB_EVENT_COUNT_EN.
//
// state   | meaning
// ST_LOW  | level low, no debounce pending
// ST_RISE | level low, counting consecutive GT samples
// ST_HIGH | level high, no debounce pending
// ST_FALL | level high, counting consecutive LT samples
module cnb_threshold_monitor
    import cnb_pkg::*;
#(
    parameter int DEB = DEB_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       RESET_InLow,
    input  logic       valid_in,
    input  logic       AgrtB_in,
    input  logic       AeqB_in,
    input  logic       AlwrB_in,
    output logic       level_out,
    output logic       rise_out,
    output logic       fall_out,
    output logic       busy_out,
    output logic       err_out
`ifdef CNB_EVENT_COUNT_EN
    ,
    output logic [7:0] event_cnt_out,
    input  logic       clr_cnt_in
`endif
);

    localparam int CW = $clog2(DEB + 1);

    state_t        state;
    state_t        stateNext;
    logic [2:0]    flags;
    logic          sampleOk;
    logic          gt;
    logic          lt;
    logic          cntInc;
    logic          cntClr;
    logic          cntHit;
    logic [CW-1:0] cnt;
    logic          levelNext;
    logic          busyNext;
    logic          riseNext;
    logic          fallNext;
    logic          errNext;

    assign flags    = {AgrtB_in, AeqB_in, AlwrB_in};
    assign sampleOk = valid_in && isOneHot(flags);
    assign gt       = sampleOk && AgrtB_in;
    assign lt       = sampleOk && AlwrB_in;

    cnb_debounce_cnt #(
        .DEB (DEB),
        .CW  (CW)
    ) u_debCnt (
        .clk   (CLOCK_50),
        .rst_n (RESET_InLow),
        .inc   (cntInc),
        .clr   (cntClr),
        .cnt   (cnt),
        .hit   (cntHit)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            state     <= ST_LOW;
            level_out <= 1'b0;
            busy_out  <= 1'b0;
            rise_out  <= 1'b0;
            fall_out  <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            state     <= stateNext;
            level_out <= levelNext;
            busy_out  <= busyNext;
            rise_out  <= riseNext;
            fall_out  <= fallNext;
            err_out   <= errNext;
        end
    end

    // In the idle states cnt is 0, so hit there means DEB==1: commit at once.
    always_comb begin
        stateNext = state;
        cntInc    = 1'b0;
        cntClr    = 1'b0;
        case (state)
            ST_LOW: begin
                if (gt) begin
                    if (cntHit) begin
                        stateNext = ST_HIGH;
                    end else begin
                        stateNext = ST_RISE;
                        cntInc    = 1'b1;
                    end
                end
            end
            ST_RISE: begin
                if (gt) begin
                    if (cntHit) begin
                        stateNext = ST_HIGH;
                        cntClr    = 1'b1;
                    end else begin
                        cntInc = 1'b1;
                    end
                end else if (lt) begin
                    stateNext = ST_LOW;
                    cntClr    = 1'b1;
                end
            end
            ST_HIGH: begin
                if (lt) begin
                    if (cntHit) begin
                        stateNext = ST_LOW;
                    end else begin
                        stateNext = ST_FALL;
                        cntInc    = 1'b1;
                    end
                end
            end
            ST_FALL: begin
                if (lt) begin
                    if (cntHit) begin
                        stateNext = ST_LOW;
                        cntClr    = 1'b1;
                    end else begin
                        cntInc = 1'b1;
                    end
                end else if (gt) begin
                    stateNext = ST_HIGH;
                    cntClr    = 1'b1;
                end
            end
            default: begin
                stateNext = ST_LOW;
                cntClr    = 1'b1;
            end
        endcase
    end

    // Cancelled debounces (RISE->LOW, FALL->HIGH) are not commits: no pulse.
    always_comb begin
        levelNext = (stateNext == ST_HIGH) || (stateNext == ST_FALL);
        busyNext  = (stateNext == ST_RISE) || (stateNext == ST_FALL);
        riseNext  = (stateNext == ST_HIGH) && ((state == ST_LOW) || (state == ST_RISE));
        fallNext  = (stateNext == ST_LOW)  && ((state == ST_HIGH) || (state == ST_FALL));
        errNext   = valid_in && !isOneHot(flags);
    end

`ifdef CNB_EVENT_COUNT_EN
    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            event_cnt_out <= 8'd0;
        end else if (clr_cnt_in) begin
            event_cnt_out <= 8'd0;
        end else if (riseNext && (event_cnt_out != 8'hFF)) begin
            event_cnt_out <= event_cnt_out + 8'd1;
        end
    end
`endif

endmodule
